// File: rtl/instr_pkg.sv
// Shared opcode, class, select and state definitions
// for the instruction-mix profiler.
package instr_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_J
  } cls_t;

  localparam int SEL_R      = 0;
  localparam int SEL_I      = 1;
  localparam int SEL_J      = 2;
  localparam int SEL_TOTAL  = 3;
  localparam int SEL_WATCH0 = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational MIPS decode: instruction class and the
// register written, if any, for watch counting.
module instr_decode
  import instr_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        watch_mode,
  output cls_t        cls,
  output logic        dest_valid,
  output logic [4:0]  dest
);

  logic [5:0] op;
  logic       writes;
  logic       unused;

  assign op     = instr[31:26];
  assign unused = ^{instr[25:21], instr[10:0]};

  always_comb begin
    cls    = CLS_I;
    dest   = instr[20:16];
    writes = watch_mode;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        cls    = CLS_R;
        dest   = instr[15:11];
        writes = 1'b1;
      end
      (op == OP_J): begin
        cls    = CLS_J;
        writes = 1'b0;
      end
      (op == OP_JAL): begin
        cls  = CLS_J;
        dest = 5'd31;
      end
      (op == OP_BEQ || op == OP_BNE ||
       op == OP_SB  || op == OP_SH  ||
       op == OP_SW  || op == OP_REGIMM):
        writes = 1'b0;
      default: ;
    endcase
    // $0 is hardwired, so a write to it never counts
    dest_valid = writes && (dest != 5'd0);
  end

endmodule

// File: rtl/instr_mix_profiler.sv
// Run-controlled instruction-mix profiler with saturating
// counters and a registered LED select mux.
module instr_mix_profiler
  import instr_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int NUM_WATCH  = 3,
  parameter int WATCH_BASE = 3,
  parameter int MAX_INSTR  = 8,
  parameter int SEL_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             watch_mode,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam int NCNT  = SEL_WATCH0 + NUM_WATCH;
  localparam int ACC_W = $clog2(MAX_INSTR + 1);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt [NCNT];
  logic [NCNT-1:0]   inc;
  logic [CNT_W-1:0]  sel_cnt;
  logic              xfer;
  cls_t              cls;
  logic              dest_valid;
  logic [4:0]        dest;

  instr_decode u_decode (
    .instr      (instr),
    .watch_mode (watch_mode),
    .cls        (cls),
    .dest_valid (dest_valid),
    .dest       (dest)
  );

  // a start in the same cycle wins over the transfer
  assign xfer = instr_valid && (state == RUN) && !start;

  always_comb begin
    inc = '0;
    if (xfer) begin
      inc[SEL_R]     = (cls == CLS_R);
      inc[SEL_I]     = (cls == CLS_I);
      inc[SEL_J]     = (cls == CLS_J);
      inc[SEL_TOTAL] = 1'b1;
      for (int k = 0; k < NUM_WATCH; k++)
        inc[SEL_WATCH0+k] = dest_valid &&
          (dest == 5'(WATCH_BASE + k));
    end
  end

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NCNT; i++)
      if (sel == SEL_W'(i))
        sel_cnt = cnt[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      led         <= '0;
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < NCNT; i++)
        cnt[i] <= '0;
    end else begin
      led <= sel_cnt;
      if (start) begin
        state       <= RUN;
        acc         <= '0;
        instr_ready <= 1'b1;
        busy        <= 1'b1;
        done        <= 1'b0;
        for (int i = 0; i < NCNT; i++)
          cnt[i] <= '0;
      end else if (xfer) begin
        acc <= acc + 1'b1;
        for (int i = 0; i < NCNT; i++)
          if (inc[i] && (cnt[i] != '1))
            cnt[i] <= cnt[i] + 1'b1;
        if (acc == ACC_W'(MAX_INSTR - 1)) begin
          state       <= DONE;
          instr_ready <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mix_profiler.sv
// Randomised + directed bench for instr_mix_profiler,
// two instances (default and CNT_W=4/MAX_INSTR=20).
module tb_instr_mix_profiler;

  localparam int NW   = 3;
  localparam int BASE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic        valid [2];
  logic        wm    [2];
  logic [31:0] ins   [2];
  logic [2:0]  sel   [2];
  logic        ready [2];
  logic        busy  [2];
  logic        done  [2];
  logic [7:0]  led0;
  logic [3:0]  led1;

  always #5 clk = ~clk;

  instr_mix_profiler dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start[0]),
    .watch_mode  (wm[0]),
    .instr_valid (valid[0]),
    .instr       (ins[0]),
    .instr_ready (ready[0]),
    .sel         (sel[0]),
    .led         (led0),
    .busy        (busy[0]),
    .done        (done[0])
  );

  instr_mix_profiler #(
    .CNT_W     (4),
    .MAX_INSTR (20)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start[1]),
    .watch_mode  (wm[1]),
    .instr_valid (valid[1]),
    .instr       (ins[1]),
    .instr_ready (ready[1]),
    .sel         (sel[1]),
    .led         (led1),
    .busy        (busy[1]),
    .done        (done[1])
  );

  // model: cnt index = sel code; st 0 idle, 1 run, 2 done
  int mcnt [2][4+NW];
  int macc [2];
  int mst  [2];
  int mled [2];
  int mmax [2] = '{8, 20};
  int msat [2] = '{255, 15};

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int led_of(int d);
    return d ? int'(led1) : int'(led0);
  endfunction

  function automatic void bump(int d, int i);
    if (mcnt[d][i] < msat[d])
      mcnt[d][i]++;
  endfunction

  function automatic void model_clear(int d);
    for (int i = 0; i < 4 + NW; i++)
      mcnt[d][i] = 0;
    macc[d] = 0;
  endfunction

  function automatic void model_edge(
    int d, bit s, bit v, logic [31:0] w,
    bit m, int sl);
    int op;
    int dst;
    mled[d] = (sl < 4 + NW) ? mcnt[d][sl] : 0;
    if (s) begin
      model_clear(d);
      mst[d] = 1;
    end else if (mst[d] == 1 && v) begin
      op  = int'(w[31:26]);
      dst = 0;
      if (op == 0) begin
        bump(d, 0);
        dst = int'(w[15:11]);
      end else if (op == 2 || op == 3) begin
        bump(d, 2);
        if (op == 3 && m) dst = 31;
      end else begin
        bump(d, 1);
        if (m && !(op inside {1, 4, 5, 40, 41, 43}))
          dst = int'(w[20:16]);
      end
      bump(d, 3);
      if (dst > 0 && dst >= BASE && dst < BASE + NW)
        bump(d, 4 + dst - BASE);
      macc[d]++;
      if (macc[d] == mmax[d]) mst[d] = 2;
    end
  endfunction

  task automatic chk_outs(int d);
    chk($sformatf("d%0d_led", d), led_of(d), mled[d]);
    chk($sformatf("d%0d_ready", d),
        int'(ready[d]), int'(mst[d] == 1));
    chk($sformatf("d%0d_busy", d),
        int'(busy[d]), int'(mst[d] == 1));
    chk($sformatf("d%0d_done", d),
        int'(done[d]), int'(mst[d] == 2));
  endtask

  task automatic step(int d, bit s, bit v,
                      logic [31:0] w, bit m, int sl);
    start[d] = s;
    valid[d] = v;
    ins[d]   = w;
    wm[d]    = m;
    sel[d]   = 3'(sl);
    @(posedge clk);
    model_edge(d, s, v, w, m, sl);
    @(negedge clk);
    start[d] = 1'b0;
    valid[d] = 1'b0;
    chk_outs(d);
  endtask

  task automatic expect_cnt(int d, int sl, int exp,
                            string tag);
    step(d, 1'b0, 1'b0, 32'h0, 1'b0, sl);
    chk(tag, led_of(d), exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      mst[d]  = 0;
      mled[d] = 0;
      chk_outs(d);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [5:0] ops [14] = '{
      6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
      6'h28, 6'h29, 6'h2B, 6'h01, 6'h23, 6'h08, 6'h0F};
    logic [4:0] rt;
    logic [4:0] rd;
    rt = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 8);
    rd = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 8);
    return {ops[$urandom % 14], 5'($urandom), rt, rd,
            11'($urandom)};
  endfunction

  localparam logic [31:0] W_ADD = 32'h00221820;
  localparam logic [31:0] W_J   = 32'h08000000;
  localparam logic [31:0] W_LW  = 32'h8C240000;
  localparam logic [31:0] W_SW  = 32'hAC250000;
  localparam logic [31:0] W_JAL = 32'h0C000000;

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      valid[d] = 1'b0;
      wm[d]    = 1'b0;
      ins[d]   = '0;
      sel[d]   = '0;
    end
    @(negedge clk);
    do_reset();

    // mixed stream, R-type writes only
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, W_ADD, 0, 0);
    step(0, 0, 1, W_J, 0, 0);
    step(0, 0, 1, W_LW, 0, 0);
    expect_cnt(0, 0, 1, "t1_r");
    expect_cnt(0, 1, 1, "t1_i");
    expect_cnt(0, 2, 1, "t1_j");
    expect_cnt(0, 3, 3, "t1_total");
    expect_cnt(0, 4, 1, "t1_w0");
    expect_cnt(0, 5, 0, "t1_w1");

    // watch_mode=1 adds I-type rt and jal
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 1, W_ADD, 1, 0);
    step(0, 0, 1, W_J, 1, 0);
    step(0, 0, 1, W_LW, 1, 0);
    step(0, 0, 1, W_SW, 1, 0);
    step(0, 0, 1, W_JAL, 1, 0);
    expect_cnt(0, 0, 1, "t2_r");
    expect_cnt(0, 1, 2, "t2_i");
    expect_cnt(0, 2, 2, "t2_j");
    expect_cnt(0, 3, 5, "t2_total");
    expect_cnt(0, 4, 1, "t2_w0");
    expect_cnt(0, 5, 1, "t2_w1");
    expect_cnt(0, 6, 0, "t2_w2");

    // auto-stop after MAX_INSTR
    step(0, 1, 0, 0, 0, 3);
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, W_ADD, 0, 3);
    chk("t3_done", int'(done[0]), 1);
    chk("t3_ready", int'(ready[0]), 0);
    expect_cnt(0, 3, 8, "t3_total");

    // restart from DONE, out-of-range select
    step(0, 1, 0, 0, 0, 7);
    chk("t6_busy", int'(busy[0]), 1);
    chk("t6_ready", int'(ready[0]), 1);
    chk("t6_led", led_of(0), 0);
    expect_cnt(0, 3, 0, "t6_total");

    // saturation on the narrow instance
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(1, 0, 1, W_ADD, 0, 0);
    expect_cnt(1, 0, 15, "t4_r");
    expect_cnt(1, 4, 15, "t4_w0");
    expect_cnt(1, 3, 15, "t4_total");
    chk("t4_done", int'(done[1]), 1);

    // reset mid-run, then a clean run
    step(0, 1, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, W_ADD, 0, 3);
    do_reset();
    for (int s = 0; s < 7; s++)
      expect_cnt(0, s, 0, "t5_zero");
    step(0, 1, 0, 0, 0, 3);
    step(0, 0, 1, W_ADD, 0, 3);
    step(0, 0, 1, W_LW, 1, 3);
    expect_cnt(0, 3, 2, "t5_total");
    expect_cnt(0, 5, 1, "t5_w1");

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int d;
      d = int'($urandom % 2);
      step(d, ($urandom % 15) == 0, ($urandom % 4) != 0,
           rand_word(), 1'($urandom), int'($urandom % 8));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mix_profiler.md
Name: instr_mix_profiler

Overview:
- Parametrised successor to the lab's fixed 8-instruction classifier. Accepts a stream of 32-bit MIPS instruction words over a valid/ready handshake.
- Classifies each word as R, I or J type and counts writes to a configurable window of destination registers.
- Counters are saturating. A selectable count is driven onto the board LEDs.
- Sits between the instruction ROM/stream source and the LED/display logic of the lab top level.

Parameters:
- CNT_W, 8: width of every counter and of led.
- NUM_WATCH, 3: number of watched destination registers.
- WATCH_BASE, 3: first watched register; watch k covers register WATCH_BASE+k, k=0..NUM_WATCH-1. Constraint: WATCH_BASE+NUM_WATCH<=32.
- MAX_INSTR, 8: instructions accepted per run before automatic stop (>=1).
- SEL_W, 3: width of sel; constraint 2^SEL_W >= 4+NUM_WATCH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear counters and begin a run
- watch_mode  in  1  0 = count R-type rd only; 1 = also count I-type rt writes and jal $31
- instr_valid  in  1  instr holds a valid word
- instr  in  32  MIPS instruction word
- instr_ready  out  1  block accepts instr this cycle
- sel  in  SEL_W  count select: 0=R, 1=I, 2=J, 3=total, 4+k=watch k
- led  out  CNT_W  registered value of the selected count
- busy  out  1  run in progress
- done  out  1  MAX_INSTR words accepted; held until next start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; all counters 0; accepted-count 0; led=0; instr_ready=0; busy=0; done=0.
- State IDLE: instr_ready=0. start -> clear all counters and accepted-count, go to RUN next cycle.
- State RUN: instr_ready=1, busy=1.
  - A transfer occurs when instr_valid&&instr_ready.
  - The transfer updates counters on the same edge.
  - On the transfer that makes accepted-count==MAX_INSTR, go to DONE. instr_ready drops the following cycle.
- State DONE: done=1, instr_ready=0, counters frozen. start -> clear and go to RUN, same as from IDLE.
- start while in RUN: restart. Counters clear, and any transfer in that same cycle is discarded.
- Classification, opcode = instr[31:26]:
  - 000000 -> R.
  - 000010 or 000011 -> J.
  - everything else -> I.
  - Exactly one of R/I/J increments per transfer. total increments on every transfer.
- Destination for watch counting:
  - R-type: rd = instr[15:11], any watch_mode.
  - watch_mode=1, I-type: rt = instr[20:16], except opcodes that write no register: 000100 beq, 000101 bne, 101000 sb, 101001 sh, 101011 sw, 000001 regimm. Those count nothing.
  - watch_mode=1, opcode 000011 (jal): destination is 31.
  - watch_mode=0: I and J never count.
  - A destination of 0 is never counted, even if inside the window.
  - A destination d in [WATCH_BASE, WATCH_BASE+NUM_WATCH) increments watch[d-WATCH_BASE]. At most one watch counter moves per transfer.
- Saturation: each counter holds at 2^CNT_W-1. No wrap. Other counters keep counting.
- watch_mode is sampled per transfer; it may change mid-run.
- led:
  - led = count selected by sel, registered. One-cycle latency from sel or counter change.
  - sel >= 4+NUM_WATCH -> led=0.
  - led stays live in RUN and DONE.
- Reset asserted mid-run: immediate return to reset values. No partial results are retained.

Decomposition:
- Shared package instr_pkg:
  - opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW, OP_REGIMM;
  - class enum {CLS_R, CLS_I, CLS_J};
  - sel codes SEL_R, SEL_I, SEL_J, SEL_TOTAL, SEL_WATCH0;
  - state enum {IDLE, RUN, DONE}.
- One sub-module: instr_decode. Purely combinational: instr, watch_mode -> class, dest_valid, dest[4:0].
- The top level holds the FSM, saturating counters and led mux.

Test Plan:
- Reset, then start; send 0x00221820 (add $3,$1,$2), 0x08000000 (j), 0x8C240000 (lw $4) with watch_mode=0 -> R=1, J=1, I=1, total=3, watch0=1, watch1=0. sel=4 gives led=1 one cycle after sel.
- Same stream with watch_mode=1, plus 0xAC250000 (sw $5) and 0x0C000000 (jal) -> watch1=1, watch2=0, J=2, I=2. $31 is not counted (outside window).
- MAX_INSTR=8: send 10 words with instr_valid held high -> exactly 8 accepted. done=1 and instr_ready=0 from the cycle after the 8th. total=8.
- CNT_W=4, MAX_INSTR=20: 20 R-type writes to $3 -> watch0 and R saturate at 15. total saturates at 15. No wrap.
- Deassert rst_n mid-run after 3 transfers -> led, busy, done and all counters read 0 immediately. A new start produces a clean run.
- start pulse in DONE with counts nonzero -> counters clear, busy=1, instr_ready=1 next cycle. sel=7 (out of range, NUM_WATCH=3) gives led=0.
